d_ff_n: RTL and testbench



---
 rtl/d_ff_n.sv | 36 +++
 tb/tb_d_ff_n.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/d_ff_n.sv
// N-bit parallel-in/parallel-out word register with synchronous load enable
// and asynchronous active-low clear.
`timescale 1ns/1ps

module d_ff_n #(
    parameter int unsigned N = 8
) (
    output logic [N-1:0] Q,
    input  logic [N-1:0] D,
    input  logic         CLK,
    input  logic         n_Reset,
    input  logic         EN
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (EN) begin
            q_d = D;
        end
    end

    // Clear is tested first so it wins over a coincident enabled load.
    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_d_ff_n.sv
// Scoreboard bench for d_ff_n at widths 8, 1 and 16: stimulus queues expected
// words, a monitor process pops and compares them against the live outputs.
`timescale 1ns/1ps

module tb_d_ff_n;

    typedef struct {
        int          sel;   // 0: N=8, 1: N=1, 2: N=16
        logic [15:0] exp;
        string       name;
    } sb_entry_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  d8,  q8;
    logic        d1,  q1;
    logic [15:0] d16, q16;
    logic        en8, en1, en16;

    sb_entry_t sb[$];
    event      chk_ev;
    int        checks;
    int        errors;

    d_ff_n #(.N(8))  u_dut8  (.Q(q8),  .D(d8),  .CLK(clk), .n_Reset(rst_n), .EN(en8));
    d_ff_n #(.N(1))  u_dut1  (.Q(q1),  .D(d1),  .CLK(clk), .n_Reset(rst_n), .EN(en1));
    d_ff_n #(.N(16)) u_dut16 (.Q(q16), .D(d16), .CLK(clk), .n_Reset(rst_n), .EN(en16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares every queued expectation when a sample point is flagged.
    initial begin
        sb_entry_t   e;
        logic [15:0] act;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    0:       act = {8'h00, q8};
                    1:       act = {15'h0000, q1};
                    default: act = q16;
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_q(input int sel, input logic [15:0] exp, input string name);
        sb_entry_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic sample();
        ->chk_ev;
        #0.001;
    endtask

    // Apply inputs at a falling edge, then sample 2 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        en8 = 1'b0; en1 = 1'b0; en16 = 1'b0;
        d8 = 8'hFF; d1 = 1'b1; d16 = 16'hFFFF;

        // Power-on clear, released before any clock edge.
        #0.010;
        rst_n = 1'b1;
        #0.001;
        expect_q(0, 16'h0000, "poweron_q8");
        expect_q(1, 16'h0000, "poweron_q1");
        expect_q(2, 16'h0000, "poweron_q16");
        sample();

        // Enabled load / all-ones.
        @(negedge clk);
        d8 = 8'b1101_0010; en8 = 1'b1;
        d1 = 1'b1;         en1 = 1'b1;
        d16 = 16'hFFFF;    en16 = 1'b1;
        step();
        expect_q(0, 16'h00D2, "load_q8");
        expect_q(1, 16'h0001, "ones_q1");
        expect_q(2, 16'hFFFF, "ones_q16");
        sample();

        // Hold on N=8 while wider/narrow instances load zeros.
        @(negedge clk);
        d8 = 8'h00;     en8 = 1'b0;
        d1 = 1'b0;
        d16 = 16'h0000;
        step();
        expect_q(0, 16'h00D2, "hold_q8");
        expect_q(1, 16'h0000, "zeros_q1");
        expect_q(2, 16'h0000, "zeros_q16");
        sample();

        @(negedge clk);
        d8 = 8'hFF;
        d1 = 1'b1;
        d16 = 16'h8001;
        step();
        expect_q(0, 16'h00D2, "hold2_q8");
        expect_q(1, 16'h0001, "reload_q1");
        expect_q(2, 16'h8001, "edge_q16");
        sample();

        @(negedge clk);
        d1 = 1'b0;      en1 = 1'b0;
        d16 = 16'h1234; en16 = 1'b0;
        step();
        expect_q(1, 16'h0001, "hold_q1");
        expect_q(2, 16'h8001, "hold_q16");
        sample();

        // Asynchronous clear between edges, then held low across enabled edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #0.001;
        expect_q(0, 16'h0000, "async_clr_q8");
        expect_q(1, 16'h0000, "async_clr_q1");
        expect_q(2, 16'h0000, "async_clr_q16");
        sample();
        en8 = 1'b1; d8 = 8'hFF;
        en1 = 1'b1; d1 = 1'b1;
        en16 = 1'b1; d16 = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            expect_q(0, 16'h0000, "clr_hold_q8");
            expect_q(1, 16'h0000, "clr_hold_q1");
            expect_q(2, 16'h0000, "clr_hold_q16");
            sample();
        end

        // Release does not change Q by itself.
        @(negedge clk);
        rst_n = 1'b1;
        d8 = 8'h5A;
        #1;
        expect_q(0, 16'h0000, "release_q8");
        sample();

        step();
        expect_q(0, 16'h005A, "reload_q8");
        expect_q(2, 16'hFFFF, "reload_q16");
        sample();

        // Mid-cycle D change is not visible until the next rising edge.
        d8 = 8'hA5;
        #1;
        expect_q(0, 16'h005A, "midcycle_q8");
        sample();
        @(negedge clk);
        #1;
        expect_q(0, 16'h005A, "negedge_q8");
        sample();
        step();
        expect_q(0, 16'h00A5, "next_edge_q8");
        sample();

        // Reset coincident with an enabled rising edge: reset wins.
        @(negedge clk);
        d8 = 8'h77;
        @(posedge clk);
        rst_n = 1'b0;
        #2;
        expect_q(0, 16'h0000, "clr_vs_load_q8");
        sample();

        #5;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
